// File: rtl/trap_return_ctrl_if.sv
// trap_return_ctrl_if: IRQ/mret request side and fetch-redirect response side of trap_return_ctrl.
interface trap_return_ctrl_if #(
   parameter int XLEN = 32,
   parameter int NUM_IRQ = 4,
   parameter int STACK_DEPTH = 4
);
   logic [NUM_IRQ-1:0] irq;
   logic mask_we;
   logic [NUM_IRQ-1:0] mask_wdata;
   logic [XLEN-1:0] pc_e;
   logic mret;
   logic redirect;
   logic [XLEN-1:0] redirect_pc;
   logic [$clog2(NUM_IRQ)-1:0] irq_id;
   logic take;
   logic [$clog2(STACK_DEPTH+1)-1:0] depth;
   logic err;
   modport master (
      output irq, mask_we, mask_wdata, pc_e, mret,
      input redirect, redirect_pc, irq_id, take, depth, err
   );
   modport slave (
      input irq, mask_we, mask_wdata, pc_e, mret,
      output redirect, redirect_pc, irq_id, take, depth, err
   );
endinterface

// File: rtl/trap_return_ctrl.sv
// trap_return_ctrl: fixed-priority IRQ controller with a nested return-address stack.
// Define VECTORED_IRQ_EN for per-source handler entries; otherwise every take goes to VEC_BASE.
module trap_return_ctrl #(
   parameter int XLEN = 32,
   parameter int NUM_IRQ = 4,
   parameter int STACK_DEPTH = 4,
   parameter logic [XLEN-1:0] VEC_BASE = 32'h000000F0,
   parameter int VEC_STRIDE = 4,
   parameter int RET_OFFSET = 8
) (
   input logic clk,
   input logic reset,
   trap_return_ctrl_if.slave bus
);
   localparam int IW = $clog2(NUM_IRQ);
   localparam int DW = $clog2(STACK_DEPTH + 1);
`ifdef VECTORED_IRQ_EN
   localparam bit VECTORED = 1'b1;
`else
   localparam bit VECTORED = 1'b0;
`endif
   localparam int STEP = VECTORED ? VEC_STRIDE : 0;
   logic [NUM_IRQ-1:0] irq_q, pending, mask, active;
   logic [DW-1:0] depth, top;
   logic [XLEN-1:0] stk_pc [2**DW];
   logic [IW-1:0] stk_id [2**DW];
   logic [IW-1:0] cand_id;
   logic cand, take, pop, err;
   logic [XLEN-1:0] handler;
   assign active = pending & mask;
   assign top = depth - DW'(1);
   always_comb begin
      cand = 1'b0;
      cand_id = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--)
         if (active[i]) begin
            cand = 1'b1;
            cand_id = IW'(i);
         end
   end
   // nesting only for strictly higher priority (lower id) than the active handler
   assign take = ~reset & cand & ~bus.mret & (depth < DW'(STACK_DEPTH))
               & ((depth == '0) | (cand_id < stk_id[top]));
   assign pop = ~reset & bus.mret & (depth != '0);
   assign handler = VEC_BASE + XLEN'(cand_id) * XLEN'(STEP);
   assign bus.take = take;
   assign bus.redirect = take | pop;
   assign bus.redirect_pc = pop ? stk_pc[top] : take ? handler : '0;
   assign bus.irq_id = take ? cand_id : '0;
   assign bus.depth = depth;
   assign bus.err = err;
   always_ff @(posedge clk)
      if (reset) begin
         irq_q <= '0;
         pending <= '0;
         mask <= '1;
         depth <= '0;
         err <= 1'b0;
      end else begin
         irq_q <= bus.irq;
         pending <= (pending & ~(take ? (NUM_IRQ'(1) << cand_id) : '0)) | (bus.irq & ~irq_q);
         if (bus.mask_we) mask <= bus.mask_wdata;
         if (bus.mret && depth == '0) err <= 1'b1;
         if (take) depth <= depth + DW'(1);
         else if (pop) depth <= depth - DW'(1);
      end
   always_ff @(posedge clk)
      if (take) begin
         stk_pc[depth] <= bus.pc_e + XLEN'(RET_OFFSET);
         stk_id[depth] <= cand_id;
      end
endmodule

// File: tb/tb_trap_return_ctrl.sv
// tb_trap_return_ctrl: directed vector table plus hand sequences for trap_return_ctrl (depth 4 and depth 2).
module tb_trap_return_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int errors = 0;
   int checks = 0;
   trap_return_ctrl_if #(.STACK_DEPTH(4)) b1 ();
   trap_return_ctrl_if #(.STACK_DEPTH(2)) b2 ();
   trap_return_ctrl #(.STACK_DEPTH(4)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
   trap_return_ctrl #(.STACK_DEPTH(2)) dut2 (.clk(clk), .reset(reset), .bus(b2.slave));
   always #5 clk = ~clk;
   typedef struct {
      logic [3:0] irq;
      logic mwe;
      logic [3:0] mdata;
      logic [31:0] pc;
      logic mret;
      logic red;
      logic [31:0] rpc;
      logic take;
      logic [1:0] id;
      int depth;
      logic err;
   } vec_t;
   function automatic logic [31:0] h(int id);
`ifdef VECTORED_IRQ_EN
      return 32'hF0 + 32'(id) * 4;
`else
      return 32'hF0;
`endif
   endfunction
   function automatic vec_t mk(logic [3:0] irq, logic mwe, logic [3:0] mdata, logic [31:0] pc, logic mret,
                               logic red, logic [31:0] rpc, logic take, logic [1:0] id, int depth, logic err);
      vec_t v;
      v.irq = irq; v.mwe = mwe; v.mdata = mdata; v.pc = pc; v.mret = mret;
      v.red = red; v.rpc = rpc; v.take = take; v.id = id; v.depth = depth; v.err = err;
      return v;
   endfunction
   function automatic vec_t q(logic [3:0] irq, logic [31:0] pc, logic mret, int depth, logic err);
      return mk(irq, 1'b0, 4'h0, pc, mret, 1'b0, 32'h0, 1'b0, 2'd0, depth, err);
   endfunction
   function automatic vec_t tk(logic [3:0] irq, logic [31:0] pc, int id, int depth, logic err);
      return mk(irq, 1'b0, 4'h0, pc, 1'b0, 1'b1, h(id), 1'b1, 2'(id), depth, err);
   endfunction
   function automatic vec_t rt(logic [31:0] ret, int depth, logic err);
      return mk(4'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, ret, 1'b0, 2'd0, depth, err);
   endfunction
   task automatic drive(vec_t v);
      b1.irq = v.irq; b1.mask_we = v.mwe; b1.mask_wdata = v.mdata; b1.pc_e = v.pc; b1.mret = v.mret;
      b2.irq = v.irq; b2.mask_we = v.mwe; b2.mask_wdata = v.mdata; b2.pc_e = v.pc; b2.mret = v.mret;
   endtask
   task automatic step(vec_t v, bit sel, string name);
      logic [44:0] got, exp;
      drive(v);
      @(negedge clk);
      exp = {v.red, v.rpc, v.take, v.id, 8'(v.depth), v.err};
      if (sel) got = {b2.redirect, b2.redirect_pc, b2.take, b2.irq_id, 8'(b2.depth), b2.err};
      else got = {b1.redirect, b1.redirect_pc, b1.take, b1.irq_id, 8'(b1.depth), b1.err};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got {red,pc,take,id,depth,err}=%h expected %h", name, got, exp);
      end
      @(posedge clk);
      #1;
   endtask
   vec_t tbl[$];
   vec_t seq[$];
   initial begin
      drive(q(4'h0, 32'h0, 1'b0, 0, 1'b0));
      tbl.push_back(q(4'h0, 32'h0, 1'b0, 0, 1'b0));
      tbl.push_back(q(4'h4, 32'h100, 1'b0, 0, 1'b0));
      tbl.push_back(tk(4'h0, 32'h100, 2, 0, 1'b0));
      tbl.push_back(q(4'h0, 32'h100, 1'b0, 1, 1'b0));
      tbl.push_back(q(4'h1, 32'h300, 1'b0, 1, 1'b0));
      tbl.push_back(tk(4'h0, 32'h300, 0, 1, 1'b0));
      tbl.push_back(rt(32'h308, 2, 1'b0));
      tbl.push_back(rt(32'h108, 1, 1'b0));
      tbl.push_back(q(4'h0, 32'h0, 1'b0, 0, 1'b0));
      tbl.push_back(q(4'h2, 32'h400, 1'b0, 0, 1'b0));
      tbl.push_back(tk(4'h0, 32'h400, 1, 0, 1'b0));
      tbl.push_back(q(4'h8, 32'h500, 1'b0, 1, 1'b0));
      tbl.push_back(q(4'h0, 32'h500, 1'b0, 1, 1'b0));
      tbl.push_back(rt(32'h408, 1, 1'b0));
      tbl.push_back(tk(4'h0, 32'h500, 3, 0, 1'b0));
      tbl.push_back(rt(32'h508, 1, 1'b0));
      tbl.push_back(q(4'h4, 32'h600, 1'b0, 0, 1'b0));
      tbl.push_back(tk(4'h0, 32'h600, 2, 0, 1'b0));
      tbl.push_back(mk(4'h2, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 32'h608, 1'b0, 2'd0, 1, 1'b0));
      tbl.push_back(tk(4'h0, 32'h700, 1, 0, 1'b0));
      tbl.push_back(q(4'h1, 32'h700, 1'b0, 1, 1'b0));
      tbl.push_back(rt(32'h708, 1, 1'b0));
      tbl.push_back(tk(4'h0, 32'h800, 0, 0, 1'b0));
      tbl.push_back(rt(32'h808, 1, 1'b0));
      tbl.push_back(q(4'h0, 32'h0, 1'b1, 0, 1'b0));
      tbl.push_back(q(4'h0, 32'h0, 1'b0, 0, 1'b1));
      tbl.push_back(mk(4'h0, 1'b1, 4'b1101, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 0, 1'b1));
      tbl.push_back(q(4'h2, 32'h0, 1'b0, 0, 1'b1));
      tbl.push_back(q(4'h0, 32'h0, 1'b0, 0, 1'b1));
      tbl.push_back(q(4'h0, 32'h0, 1'b0, 0, 1'b1));
      tbl.push_back(mk(4'h0, 1'b1, 4'hF, 32'h900, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 0, 1'b1));
      tbl.push_back(tk(4'h0, 32'h900, 1, 0, 1'b1));
      tbl.push_back(rt(32'h908, 1, 1'b1));
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      foreach (tbl[i]) step(tbl[i], 1'b0, $sformatf("tbl[%0d]", i));
      // new edge on the source being taken: pending survives; also return PC wraps
      step(mk(4'h0, 1'b1, 4'b0111, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 0, 1'b1), 1'b0, "edge_mask");
      step(q(4'h8, 32'h0, 1'b0, 0, 1'b1), 1'b0, "edge_masked_pulse");
      step(mk(4'h0, 1'b1, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 0, 1'b1), 1'b0, "edge_unmask");
      step(tk(4'h8, 32'hFFFF_FFFC, 3, 0, 1'b1), 1'b0, "edge_take_with_edge");
      step(q(4'h0, 32'h0, 1'b0, 1, 1'b1), 1'b0, "edge_no_self_nest");
      step(rt(32'h0000_0004, 1, 1'b1), 1'b0, "edge_wrap_ret");
      step(tk(4'h0, 32'h10, 3, 0, 1'b1), 1'b0, "edge_retaken");
      step(rt(32'h18, 1, 1'b1), 1'b0, "edge_ret2");
      // reset while nested with a pending source
      step(q(4'h1, 32'h40, 1'b0, 0, 1'b1), 1'b0, "rst_pulse");
      step(tk(4'h4, 32'h40, 0, 0, 1'b1), 1'b0, "rst_take");
      drive(q(4'h0, 32'h0, 1'b1, 0, 1'b0));
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({b1.redirect, b1.take} !== 2'b00) begin
         errors++;
         $display("FAIL rst_no_redirect: got {redirect,take}=%b expected 00", {b1.redirect, b1.take});
      end
      @(posedge clk);
      #1 reset = 1'b0;
      step(q(4'h0, 32'h0, 1'b0, 0, 1'b0), 1'b0, "rst_cleared");
      step(q(4'h0, 32'h0, 1'b0, 0, 1'b0), 1'b0, "rst_pending_gone");
      // depth-2 instance: full stack holds a higher-priority source until mret
      seq.push_back(q(4'h8, 32'h100, 1'b0, 0, 1'b0));
      seq.push_back(tk(4'h0, 32'h100, 3, 0, 1'b0));
      seq.push_back(q(4'h4, 32'h200, 1'b0, 1, 1'b0));
      seq.push_back(tk(4'h0, 32'h200, 2, 1, 1'b0));
      seq.push_back(q(4'h1, 32'h200, 1'b0, 2, 1'b0));
      seq.push_back(q(4'h0, 32'h200, 1'b0, 2, 1'b0));
      seq.push_back(q(4'h0, 32'h200, 1'b0, 2, 1'b0));
      seq.push_back(rt(32'h208, 2, 1'b0));
      seq.push_back(tk(4'h0, 32'h300, 0, 1, 1'b0));
      seq.push_back(rt(32'h308, 2, 1'b0));
      seq.push_back(rt(32'h108, 1, 1'b0));
      seq.push_back(q(4'h0, 32'h0, 1'b0, 0, 1'b0));
      foreach (seq[i]) step(seq[i], 1'b1, $sformatf("full[%0d]", i));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
